load_use_scoreboard: RTL and testbench
======================================

# load_use_scoreboard

Hazard-detection companion to the EX-stage forwarding logic in the 5-stage MIPS pipeline. The forwarding path consumes in-flight results at EX. This block sits at ID and tracks the producers: every issued instruction's destination as it moves through EX, MEM and WB. It stalls ID when a source register depends on a load whose data cannot yet be forwarded. It also keeps a saturating stall-cycle counter for lab performance reporting.

## Interface
- `LOAD_USE_DEPTH`, 1 — number of stages after EX in which load data is not yet forwardable. Legal values: 1 (data at MEM/WB) and 2 (data at WB only).
- `CNT_W`, 16 — width of the stall counter.

- `clk`  in  1  — pipeline clock. One clock domain only.
- `reset`  in  1  — asynchronous, active-high. Clears all state.
- `issue_valid`  in  1  — a valid instruction is leaving ID this cycle.
- `issue_rd`  in  5  — destination register of the issuing instruction.
- `issue_regWrite`  in  1  — issuing instruction writes the register file.
- `issue_memRead`  in  1  — issuing instruction is a load.
- `flush`  in  1  — squash: the instruction entering EX becomes a bubble.
- `rs_FD`  in  5  — rs of the instruction currently in ID.
- `rt_FD`  in  5  — rt of the instruction currently in ID.
- `use_rs`  in  1  — the ID instruction reads rs.
- `use_rt`  in  1  — the ID instruction reads rt.
- `stall`  out  1  — hold PC and the IF/ID register, and insert a bubble into EX.
- `busy`  out  1  — at least one valid entry is in flight.
- `stall_count`  out  CNT_W  — saturating count of stalled cycles.

## Operation
- The shadow pipeline has three entries: `ex`, `mem`, `wb`. Each entry holds {valid, rd, regWrite, memRead}.
- Each rising edge, the entries shift: wb <= mem, mem <= ex.
- On the same edge, ex is loaded as follows:
  - ex <= bubble (valid=0) if flush is high.
  - Otherwise ex <= bubble if stall is high.
  - Otherwise ex <= bubble if issue_valid is low.
  - Otherwise ex <= {1, issue_rd, issue_regWrite, issue_memRead}.
- Priority is flush > stall > issue. An issue during stall is dropped; ID holds it and re-presents it next cycle.
- An entry is a *pending load* when valid && regWrite && memRead && rd != 0.
- Entry x matches the ID instruction when (use_rs && x.rd == rs_FD) || (use_rt && x.rd == rt_FD).
- stall is combinational: it is high when a pending-load `ex` entry matches.
- When LOAD_USE_DEPTH = 2, stall is also high when a pending-load `mem` entry matches.
- Register 0 never causes a stall, whatever regWrite says.
- Non-load producers (memRead = 0) never stall; forwarding covers them.
- busy = ex.valid | mem.valid | wb.valid.
- stall_count increments on every edge where stall = 1. It holds at all-ones and does not wrap.

## Timing
- Reset asserted: all entries become invalid immediately, without waiting for a clock edge. stall and busy drop to 0 combinationally. stall_count becomes 0.
- Reset applied mid-stall: stall falls within the same cycle.
- Reset deassertion: the first shift occurs on the first rising edge with reset low.
- Stall is combinational, from flops plus the ID inputs. It is valid in the same cycle that rs_FD and rt_FD are presented.
- Stall duration for a load followed immediately by a dependent instruction:
  - LOAD_USE_DEPTH = 1: exactly 1 cycle.
  - LOAD_USE_DEPTH = 2: exactly 2 cycles.
- With one independent instruction between the load and its consumer:
  - LOAD_USE_DEPTH = 1: no stall.
  - LOAD_USE_DEPTH = 2: 1 cycle.
- Flush in the same cycle as a stall: a bubble is inserted and the stall still counts.
- rs_FD == rt_FD == rd with both used: a single stall, not a doubled one.
- The entry count cannot overflow because it is a fixed 3-stage shift.

## Structure
- Shared package `pipe_pkg` holds:
  - `REG_ADDR_W = 5` and `REG_ZERO = 5'd0`.
  - A packed struct `sb_entry_t` {valid, rd, regWrite, memRead} and the constant `SB_BUBBLE`.
  - A function `is_pending_load(sb_entry_t)`.
- One sub-module, `sb_stage`: a single entry register with asynchronous reset to SB_BUBBLE, a load enable and a bubble-select input. It is instantiated three times.
- The stall comparator and counter live in the top level.

## Test plan
- Load r3 (LOAD_USE_DEPTH = 1), then next cycle an instruction with use_rs = 1, rs_FD = 3 → stall = 1 for exactly 1 cycle; ex is a bubble the next cycle; stall_count = 1.
- The same sequence with LOAD_USE_DEPTH = 2 → stall for 2 consecutive cycles; stall_count = 2.
- Load r0, then a consumer of r0; and separately an ALU op (memRead = 0) writing r5 followed by a consumer of r5 → stall stays 0 in both cases.
- Load r7 with flush asserted in the same cycle as the issue, then a consumer of r7 → no stall, because the entry was squashed; busy = 0 after 3 cycles.
- Force stall_count to near-full with CNT_W = 2, then hold stall for 5 cycles → count reads 3 and stays at 3.
- Load r4, dependent consumer present, assert reset during the stall cycle → stall and busy are 0 immediately, stall_count = 0, and normal issue resumes after reset is released.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID-stage load-use scoreboard.
// One shadow-pipeline entry type plus the hazard predicates applied to it.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: REG_ZERO, regWrite: 1'b0, memRead: 1'b0};

  // r0 is hardwired, so a load targeting it never produces a real dependency.
  function automatic logic is_pending_load(input sb_entry_t e);
    return e.valid && e.regWrite && e.memRead && (e.rd != REG_ZERO);
  endfunction

  function automatic logic entry_matches(
    input sb_entry_t             e,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  use_rs,
    input logic                  use_rt
  );
    return (use_rs && (e.rd == rs)) || (use_rt && (e.rd == rt));
  endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle: issue info, ID sources, stall/status back.
// The ID stage holds the master modport, the scoreboard the slave modport.
interface load_use_scoreboard_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_regWrite;
  logic                  issue_memRead;
  logic                  flush;
  logic [REG_ADDR_W-1:0] rs_FD;
  logic [REG_ADDR_W-1:0] rt_FD;
  logic                  use_rs;
  logic                  use_rt;
  logic                  stall;
  logic                  busy;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output issue_valid, issue_rd, issue_regWrite, issue_memRead, flush,
    output rs_FD, rt_FD, use_rs, use_rt,
    input  stall, busy, stall_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_regWrite, issue_memRead, flush,
    input  rs_FD, rt_FD, use_rs, use_rt,
    output stall, busy, stall_count
  );

endinterface

// File: rtl/load_use_scoreboard_sb_stage.sv
// One shadow-pipeline entry register, async reset to a bubble.
// When enabled it captures either its input entry or a bubble.
module sb_stage
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      bubble,
  input  sb_entry_t d,
  output sb_entry_t q
);

  sb_entry_t q_q;
  sb_entry_t q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = bubble ? SB_BUBBLE : d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= SB_BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard detector at ID: shadows EX/MEM/WB producers and stalls ID on
// a source that depends on a load not yet forwardable; counts stalled cycles.
module load_use_scoreboard
  import pipe_pkg::*;
#(
  parameter int LOAD_USE_DEPTH = 1,
  parameter int CNT_W          = 16
) (
  input logic                  clk,
  input logic                  reset,
  load_use_scoreboard_if.slave sb
);

  sb_entry_t issue_ent;
  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;
  logic      ex_bubble;
  logic      ex_hit;
  logic      mem_hit;
  logic      stall;

  assign issue_ent = '{valid:    1'b1,
                       rd:       sb.issue_rd,
                       regWrite: sb.issue_regWrite,
                       memRead:  sb.issue_memRead};

  // Flush and stall both force a bubble into EX; an issue during stall is dropped.
  assign ex_bubble = sb.flush | stall | ~sb.issue_valid;

  sb_stage u_ex (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .bubble (ex_bubble),
    .d      (issue_ent),
    .q      (ex_q)
  );

  sb_stage u_mem (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  sb_stage u_wb (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  always_comb begin
    ex_hit  = is_pending_load(ex_q)
              && entry_matches(ex_q, sb.rs_FD, sb.rt_FD, sb.use_rs, sb.use_rt);
    mem_hit = 1'b0;
    // With the longer load latency, data is still missing while the load sits in MEM.
    if (LOAD_USE_DEPTH >= 2) begin
      mem_hit = is_pending_load(mem_q)
                && entry_matches(mem_q, sb.rs_FD, sb.rt_FD, sb.use_rs, sb.use_rt);
    end
    stall = ex_hit | mem_hit;
  end

  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign sb.stall       = stall;
  assign sb.busy        = ex_q.valid | mem_q.valid | wb_q.valid;
  assign sb.stall_count = stall_count_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Scoreboard bench: three scoreboards (depth 1, depth 2, depth 2 with a 2-bit
// counter) share one stimulus stream and are checked against a history model.
module tb_load_use_scoreboard;

  logic clk;
  logic reset;

  load_use_scoreboard_if #(.CNT_W(16)) ifa ();
  load_use_scoreboard_if #(.CNT_W(16)) ifb ();
  load_use_scoreboard_if #(.CNT_W(2))  ifc ();

  load_use_scoreboard #(.LOAD_USE_DEPTH(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .sb(ifa));
  load_use_scoreboard #(.LOAD_USE_DEPTH(2), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .sb(ifb));
  load_use_scoreboard #(.LOAD_USE_DEPTH(2), .CNT_W(2))  dut_c (.clk(clk), .reset(reset), .sb(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst, rst_mid, iv, rw, mr, fl, urs, urt;
    logic [4:0] rd, rs, rt;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit rw, mr;
  } ent_t;

  typedef struct packed {
    logic [2:0]       st;
    logic [2:0]       bz;
    logic [2:0][31:0] cn;
  } exp_t;

  localparam int DEP [3]  = '{1, 2, 2};
  localparam int CMAX [3] = '{65535, 65535, 3};

  // hist[d][0] is what most recently entered EX, [1] the one before, [2] before that.
  ent_t hist [3][3];
  int   cnt [3];
  vec_t cur;
  exp_t exp_q [$];
  int   n_vec;
  int   n_bad;

  function automatic bit pend(input ent_t e);
    return e.v && e.rw && e.mr && (e.rd != 0);
  endfunction

  function automatic bit m_stall(input int d);
    bit s;
    s = 1'b0;
    for (int k = 0; k < DEP[d]; k++) begin
      if (pend(hist[d][k]) &&
          ((cur.urs && hist[d][k].rd == int'(cur.rs)) ||
           (cur.urt && hist[d][k].rd == int'(cur.rt))))
        s = 1'b1;
    end
    return s;
  endfunction

  task automatic m_clear();
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0;
      for (int k = 0; k < 3; k++) hist[d][k] = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
    end
  endtask

  task automatic m_edge();
    bit s;
    if (cur.rst) begin
      m_clear();
    end else begin
      for (int d = 0; d < 3; d++) begin
        s = m_stall(d);
        if (s && cnt[d] < CMAX[d]) cnt[d]++;
        hist[d][2] = hist[d][1];
        hist[d][1] = hist[d][0];
        if (cur.fl || s || !cur.iv)
          hist[d][0] = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
        else
          hist[d][0] = '{v: 1'b1, rd: int'(cur.rd), rw: cur.rw, mr: cur.mr};
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      if (!cur.rst) begin
        e.st[d] = m_stall(d);
        e.bz[d] = hist[d][0].v | hist[d][1].v | hist[d][2].v;
        e.cn[d] = cnt[d];
      end
    end
    exp_q.push_back(e);
  endtask

  `define DRV(I) I.issue_valid = v.iv; I.issue_rd = v.rd; I.issue_regWrite = v.rw; I.issue_memRead = v.mr; I.flush = v.fl; I.rs_FD = v.rs; I.rt_FD = v.rt; I.use_rs = v.urs; I.use_rt = v.urt;

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    m_edge();
    cur = v;
    cur.rst_mid = 1'b0;
    reset = v.rst;
    `DRV(ifa)
    `DRV(ifb)
    `DRV(ifc)
    if (v.rst) m_clear();
    push_expect();
    if (v.rst_mid) begin
      #5;
      reset = 1'b1;
      cur.rst = 1'b1;
      m_clear();
      push_expect();
    end
  endtask

  function automatic vec_t mk(input bit iv, input int rd, input bit rw, input bit mr, input bit fl,
                              input bit urs, input int rs, input bit urt, input int rt);
    vec_t v;
    v.rst = 1'b0; v.rst_mid = 1'b0;
    v.iv = iv; v.rd = 5'(rd); v.rw = rw; v.mr = mr; v.fl = fl;
    v.urs = urs; v.rs = 5'(rs); v.urt = urt; v.rt = 5'(rt);
    return v;
  endfunction

  task automatic chk(input string name, input int d, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", name, d, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each expectation is compared shortly after it is queued.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      chk("stall", 0, longint'(ifa.stall), longint'(e.st[0]));
      chk("stall", 1, longint'(ifb.stall), longint'(e.st[1]));
      chk("stall", 2, longint'(ifc.stall), longint'(e.st[2]));
      chk("busy", 0, longint'(ifa.busy), longint'(e.bz[0]));
      chk("busy", 1, longint'(ifb.busy), longint'(e.bz[1]));
      chk("busy", 2, longint'(ifc.busy), longint'(e.bz[2]));
      chk("stall_count", 0, longint'(ifa.stall_count), longint'(e.cn[0]));
      chk("stall_count", 1, longint'(ifb.stall_count), longint'(e.cn[1]));
      chk("stall_count", 2, longint'(ifc.stall_count), longint'(e.cn[2]));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur.rst = 1'b1;
    m_clear();

    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); v.rst = 1'b1;
    step(v); step(v);

    // load r3 then immediate consumer on rs, re-presented while stalled
    step(mk(1, 3, 1, 1, 0, 0, 0, 0, 0));
    repeat (3) step(mk(1, 8, 1, 0, 0, 1, 3, 0, 0));
    // one independent instruction between load and consumer (rt path)
    step(mk(1, 3, 1, 1, 0, 0, 0, 0, 0));
    step(mk(1, 9, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) step(mk(1, 10, 1, 0, 0, 0, 0, 1, 3));
    // load to r0, then ALU producer of r5: neither may stall
    step(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
    step(mk(1, 11, 1, 0, 0, 1, 0, 1, 0));
    step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0));
    step(mk(1, 12, 1, 0, 0, 1, 5, 1, 5));
    // squashed load r7, then drain until idle
    step(mk(1, 7, 1, 1, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 1, 7, 0, 0));
    repeat (4) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // rs == rt == rd, both used
    step(mk(1, 6, 1, 1, 0, 0, 0, 0, 0));
    repeat (3) step(mk(1, 13, 1, 0, 0, 1, 6, 1, 6));
    // flush coinciding with a stall
    step(mk(1, 2, 1, 1, 0, 0, 0, 0, 0));
    repeat (3) step(mk(1, 14, 1, 0, 1, 1, 2, 0, 0));
    // reset asserted in the middle of a stall cycle, then normal issue
    step(mk(1, 4, 1, 1, 0, 0, 0, 0, 0));
    v = mk(1, 15, 1, 0, 0, 1, 4, 0, 0); v.rst_mid = 1'b1;
    step(v);
    step(mk(1, 4, 1, 1, 0, 0, 0, 0, 0));
    repeat (3) step(mk(1, 16, 1, 0, 0, 1, 4, 0, 0));

    for (int i = 0; i < 600; i++) begin
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1), $urandom_range(0, 9) == 0,
             $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7));
      v.rst = ($urandom_range(0, 99) == 0);
      v.rst_mid = !v.rst && ($urandom_range(0, 99) == 0);
      step(v);
    end

    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
